// File: rtl/minibus_pkg.sv
// rtl/minibus_pkg.sv - minibus widths, width encodings, master state and command/bus types
package minibus_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] MB_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MB_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MB_WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } minibus_master_state_t;

  typedef struct packed {
    logic                  wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [1:0]            width;
    logic                  is_signed;
  } minibus_cmd_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wen;
    logic                  ren;
    logic [1:0]            width;
  } minibus_req_t;

  typedef struct packed {
    logic                  ack;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } minibus_res_t;

  // Half accesses need 2-byte alignment, word accesses 4-byte; width 11 never legal.
  function automatic logic cmd_legal(input logic [1:0] width, input logic [1:0] addr_lo);
    case (width)
      MB_WIDTH_BYTE: cmd_legal = 1'b1;
      MB_WIDTH_HALF: cmd_legal = (addr_lo[0] == 1'b0);
      MB_WIDTH_WORD: cmd_legal = (addr_lo == 2'b00);
      default:       cmd_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/minibus_master_if.sv
// rtl/minibus_master_if.sv - minibus request/response bundle with master and slave views
interface minibus_master_if;
  import minibus_pkg::*;

  minibus_req_t req;
  minibus_res_t res;

  modport master (output req, input res);
  modport slave  (input req, output res);

endinterface

// File: rtl/minibus_load_ext.sv
// rtl/minibus_load_ext.sv - sign/zero extension of right-aligned load data by access width
module minibus_load_ext
  import minibus_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            width,
  input  logic                  is_signed,
  output logic [DATA_WIDTH-1:0] data
);

  always_comb begin
    data = rdata;
    case (width)
      MB_WIDTH_BYTE: data = {{(DATA_WIDTH-8){is_signed & rdata[7]}}, rdata[7:0]};
      MB_WIDTH_HALF: data = {{(DATA_WIDTH-16){is_signed & rdata[15]}}, rdata[15:0]};
      default:       data = rdata;
    endcase
  end

endmodule

// File: rtl/minibus_master_ctrl.sv
// rtl/minibus_master_ctrl.sv - single-outstanding minibus initiator; MINIBUS_MASTER_TIMEOUT_EN adds a REQ timeout
module minibus_master_ctrl
  import minibus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    nrst,
  minibus_master_if.master        _masterif,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wen,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [1:0]              cmd_width,
  input  logic                    cmd_signed,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  minibus_master_state_t state, state_nxt;
  minibus_cmd_t          cmd_q;
  minibus_req_t          req_d;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  cmd_ok;
  logic                  bus_done;
  logic                  timeout_hit;

  assign cmd_ok   = cmd_legal(cmd_width, cmd_addr[1:0]);
  assign bus_done = _masterif.res.ack | _masterif.res.err;

`ifdef MINIBUS_MASTER_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_cnt;

  // Held at zero outside REQ, so every REQ entry starts counting from zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)              tmo_cnt <= '0;
    else if (state != REQ)  tmo_cnt <= '0;
    else                    tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout_hit = (state == REQ) && !bus_done && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = cmd_ok ? REQ : RESP;
      REQ:     if (bus_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cmd_q       <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q.wen       <= cmd_wen;
            cmd_q.addr      <= cmd_addr;
            cmd_q.wdata     <= cmd_wdata;
            cmd_q.width     <= cmd_width;
            cmd_q.is_signed <= cmd_signed;
            rsp_err_q       <= ~cmd_ok;
            rsp_rdata_q     <= '0;
          end
        end
        REQ: begin
          // err takes priority over a simultaneous ack
          if (_masterif.res.err || timeout_hit) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else if (_masterif.res.ack) begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= cmd_q.wen ? '0 : load_data;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  minibus_load_ext u_load_ext (
    .rdata     (_masterif.res.rdata),
    .width     (cmd_q.width),
    .is_signed (cmd_q.is_signed),
    .data      (load_data)
  );

  // Strobes drop outside REQ so a slave never sees a held request and re-acks.
  always_comb begin
    req_d       = '0;
    req_d.addr  = cmd_q.addr;
    req_d.wdata = cmd_q.wdata;
    req_d.width = cmd_q.width;
    req_d.wen   = (state == REQ) &  cmd_q.wen;
    req_d.ren   = (state == REQ) & ~cmd_q.wen;
  end

  assign _masterif.req = req_d;
  assign cmd_ready     = (state == IDLE);
  assign rsp_valid     = (state == RESP);
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_minibus_master_ctrl.sv
// tb/tb_minibus_master_ctrl.sv - randomized self-checking bench for minibus_master_ctrl against a byte-array memory model
module tb_minibus_master_ctrl;
  import minibus_pkg::*;

  localparam int TIMEOUT_CYCLES = 16;

  logic                  clk = 1'b0;
  logic                  nrst = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic                  cmd_wen = 1'b0;
  logic [ADDR_WIDTH-1:0] cmd_addr = '0;
  logic [DATA_WIDTH-1:0] cmd_wdata = '0;
  logic [1:0]            cmd_width = 2'b00;
  logic                  cmd_signed = 1'b0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  always #5 clk = ~clk;

  minibus_master_if bus ();

  minibus_master_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk        (clk),
    .nrst       (nrst),
    ._masterif  (bus),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wen    (cmd_wen),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_width  (cmd_width),
    .cmd_signed (cmd_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference memory (model) and the slave's own memory start identical.
  logic [7:0] ref_mem [0:127];
  logic [7:0] slv_mem [0:127];

  int slave_delay = 0;
  bit slave_err   = 1'b0;
  bit slave_hang  = 1'b0;
  int wait_cnt    = 0;

  initial begin
    int n;
    int a;
    logic [31:0] v;
    bus.res <= '0;
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        bus.res  <= '0;
        wait_cnt = 0;
      end else if ((bus.req.wen || bus.req.ren) && !bus.res.ack && !bus.res.err && !slave_hang) begin
        if (wait_cnt >= slave_delay) begin
          wait_cnt = 0;
          n = 1 << bus.req.width;
          a = int'(bus.req.addr[6:0]);
          if (slave_err) begin
            bus.res.err   <= 1'b1;
            bus.res.ack   <= 1'($urandom & 1);
            bus.res.rdata <= $urandom;
          end else begin
            v = $urandom;
            for (int i = 0; i < n && i < 4; i++) begin
              if (bus.req.wen) slv_mem[(a + i) & 127] = bus.req.wdata[8*i +: 8];
              else             v[8*i +: 8] = slv_mem[(a + i) & 127];
            end
            bus.res.ack   <= 1'b1;
            bus.res.err   <= 1'b0;
            bus.res.rdata <= v;
          end
        end else begin
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        bus.res  <= '0;
        wait_cnt = 0;
      end
    end
  end

  // Bus monitor: counts request starts and flags unstable or out-of-place requests.
  int          req_starts = 0;
  bit          req_bad    = 1'b0;
  bit          resp_bus   = 1'b0;
  logic [31:0] exp_addr   = '0;
  logic [31:0] exp_wdata  = '0;
  logic [1:0]  exp_width  = '0;
  logic        exp_wen    = 1'b0;

  initial begin
    bit act;
    bit prev_act = 1'b0;
    forever begin
      @(negedge clk);
      act = bus.req.wen | bus.req.ren;
      if (act && !prev_act) req_starts++;
      if (act && ((bus.req.wen && bus.req.ren) || bus.req.addr !== exp_addr || bus.req.wdata !== exp_wdata ||
                  bus.req.width !== exp_width || bus.req.wen !== exp_wen))
        req_bad = 1'b1;
      if (act && rsp_valid) resp_bus = 1'b1;
      prev_act = act;
    end
  end

  function automatic logic [31:0] ref_load(input int addr, input int n, input bit sgn);
    longint v;
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[addr + i]) << (8 * i));
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic do_cmd(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] width, input bit sgn, input int delay, input bit serr,
                        input bit hang, input int hold, output logic [31:0] got_data);
    int          n;
    bit          legal;
    bit          exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
    int          lat;
    int          starts0;
    logic [31:0] r_data;
    logic        r_err;
    bit          stable;

    n       = 1 << width;
    legal   = (width != 2'b11) && ((addr % n) == 0);
    exp_err = !legal || serr || hang;
    exp_data = '0;
    if (!exp_err && !wen) exp_data = ref_load(int'(addr), n, sgn);
    if (!exp_err && wen)
      for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
    exp_lat = !legal ? 1 : (hang ? 1 + TIMEOUT_CYCLES : 3 + delay);

    @(negedge clk);
    check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    slave_delay = delay;
    slave_err   = serr;
    slave_hang  = hang;
    exp_addr    = addr;
    exp_wdata   = wdata;
    exp_width   = width;
    exp_wen     = wen;
    starts0     = req_starts;
    req_bad     = 1'b0;
    resp_bus    = 1'b0;
    cmd_wen     = wen;
    cmd_addr    = addr;
    cmd_wdata   = wdata;
    cmd_width   = width;
    cmd_signed  = sgn;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_addr   = $urandom;
    cmd_wdata  = $urandom;
    cmd_width  = 2'($urandom);
    cmd_signed = 1'($urandom);
    cmd_wen    = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_eq("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    check_eq("rsp_latency", 32'(lat), 32'(exp_lat));
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_eq("rsp_rdata", rsp_rdata, exp_data);
    check_eq("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    got_data = rsp_rdata;
    r_data   = rsp_rdata;
    r_err    = rsp_err;
    stable   = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== r_data || rsp_err !== r_err || cmd_ready) stable = 1'b0;
    end
    check_eq("rsp_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_done", 32'({rsp_valid, cmd_ready}), 32'd1);
    check_eq("bus_requests", 32'(req_starts - starts0), legal ? 32'd1 : 32'd0);
    check_eq("req_fields", 32'(req_bad), 32'd0);
    check_eq("req_in_resp", 32'(resp_bus), 32'd0);
    slave_hang = 1'b0;
    slave_err  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          r;
    int          w;
    logic [31:0] a;
    bit          stray;

    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      slv_mem[i] = ref_mem[i];
    end

    repeat (3) @(negedge clk);
    check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("reset_rsp", {29'd0, rsp_valid, rsp_err, 1'b0}, 32'd0);
    check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("reset_req_strobes", 32'({bus.req.wen, bus.req.ren}), 32'd0);
    check_eq("reset_req_addr", bus.req.addr, 32'd0);
    check_eq("reset_req_wdata_width", bus.req.wdata | 32'(bus.req.width), 32'd0);
    nrst = 1'b1;

    do_cmd(1'b1, 32'h4, 32'hDEADBEEF, MB_WIDTH_WORD, 1'b0, 0, 1'b0, 1'b0, 0, d);
    do_cmd(1'b0, 32'h4, 32'h0, MB_WIDTH_WORD, 1'b0, 0, 1'b0, 1'b0, 0, d);
    check_eq("word_load_value", d, 32'hDEADBEEF);

    do_cmd(1'b1, 32'h5, 32'h0000_0080, MB_WIDTH_BYTE, 1'b0, 1, 1'b0, 1'b0, 0, d);
    do_cmd(1'b0, 32'h5, 32'h0, MB_WIDTH_BYTE, 1'b1, 0, 1'b0, 1'b0, 0, d);
    check_eq("byte_load_signed", d, 32'hFFFFFF80);
    do_cmd(1'b0, 32'h5, 32'h0, MB_WIDTH_BYTE, 1'b0, 2, 1'b0, 1'b0, 0, d);
    check_eq("byte_load_unsigned", d, 32'h00000080);

    do_cmd(1'b0, 32'h3, 32'h0, MB_WIDTH_HALF, 1'b0, 0, 1'b0, 1'b0, 0, d);
    do_cmd(1'b1, 32'h8, 32'h1234, 2'b11, 1'b0, 0, 1'b0, 1'b0, 0, d);
    do_cmd(1'b0, 32'h8, 32'h0, MB_WIDTH_WORD, 1'b0, 0, 1'b0, 1'b0, 5, d);
    do_cmd(1'b0, 32'hC, 32'h0, MB_WIDTH_WORD, 1'b0, 1, 1'b1, 1'b0, 2, d);
    do_cmd(1'b1, 32'h10, 32'hA5A5_5A5A, MB_WIDTH_HALF, 1'b0, 0, 1'b1, 1'b0, 1, d);
`ifdef MINIBUS_MASTER_TIMEOUT_EN
    do_cmd(1'b0, 32'h20, 32'h0, MB_WIDTH_WORD, 1'b0, 0, 1'b0, 1'b1, 0, d);
`else
    do_cmd(1'b0, 32'h20, 32'h0, MB_WIDTH_WORD, 1'b0, 40, 1'b0, 1'b0, 0, d);
`endif

    // Reset while a load is waiting in REQ.
    @(negedge clk);
    slave_delay = 30;
    exp_addr    = 32'h24;
    exp_wdata   = 32'h0;
    exp_width   = MB_WIDTH_WORD;
    exp_wen     = 1'b0;
    cmd_wen     = 1'b0;
    cmd_addr    = 32'h24;
    cmd_wdata   = 32'h0;
    cmd_width   = MB_WIDTH_WORD;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_ren", 32'(bus.req.ren), 32'd1);
    nrst = 1'b0;
    #1;
    check_eq("mid_reset_strobes", 32'({bus.req.wen, bus.req.ren}), 32'd0);
    check_eq("mid_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    nrst  = 1'b1;
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || bus.req.wen || bus.req.ren || !cmd_ready) stray = 1'b1;
    end
    check_eq("post_reset_quiet", 32'(stray), 32'd0);

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 7);
      w = (r == 7) ? 3 : (r % 3);
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~(32'(1 << w) - 32'd1);
      do_cmd(1'($urandom), a, $urandom, 2'(w), 1'($urandom), $urandom_range(0, 4),
             ($urandom_range(0, 7) == 0), 1'b0, $urandom_range(0, 3), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
